// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream consumer slice.
// BYTE_W: the datapath byte width.
// LEN_W_DEF: the default width of the message-length and byte counters.
// KS_DEPTH_DEF: the default keystream FIFO depth.
// state_t: the sequencing FSM encoding used by rc4_xor_stream.
package rc4_pkg;

    localparam int BYTE_W       = 8;
    localparam int LEN_W_DEF    = 8;
    localparam int KS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small synchronous FIFO that buffers keystream bytes ahead of the XOR stage.
// The head is presented combinationally, so a pop and the use of its data
// happen in the same cycle.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (reset empties the FIFO)
//   push        write wdata; ignored when full, even if a pop happens in the same cycle
//   pop         drop the head; ignored when empty
//   wdata       byte to write
//   rdata       current head byte (combinational)
//   full        DEPTH entries held
//   empty       no entries held
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = KS_DEPTH_DEF,
    parameter int W     = BYTE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // The full flag is taken from the registered count, so a same-cycle pop
    // never opens room for a push.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rc4_xor_stream.sv
// Consumer end of the RC4 keystream generator. Keystream bytes are buffered
// in a small FIFO; each accepted message byte is combined with the FIFO head
// and registered as dout = din ^ ks. Encryption and decryption are the same
// operation. One message of msg_len bytes is processed per start.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, msg_len        begin a message (honoured only in IDLE), length latched with it
//   ks_valid/ks_data/ks_ready      keystream input handshake
//   din_valid/din/din_ready        message byte input handshake
//   dout_valid/dout/dout_last/dout_ready  output handshake; dout_last marks the final byte
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse once the message is complete
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | taking keystream and message bytes
// ST_DRAIN | last message byte taken, waiting for its output handshake
// ST_FIN   | message complete, done pulses for this single cycle
module rc4_xor_stream
    import rc4_pkg::*;
#(
    parameter int KS_DEPTH = KS_DEPTH_DEF,
    parameter int LEN_W    = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              ks_valid,
    input  logic [BYTE_W-1:0] ks_data,
    output logic              ks_ready,
    input  logic              din_valid,
    input  logic [BYTE_W-1:0] din,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_nx;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  kcnt;
    logic [LEN_W-1:0]  dcnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] ks_head;
    logic              ks_fire;
    logic              din_fire;
    logic              dout_fire;
    logic              last_byte;
    logic              start_ok;

    rc4_ks_fifo #(
        .DEPTH (KS_DEPTH),
        .W     (BYTE_W)
    ) u_ks_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ks_fire),
        .pop   (din_fire),
        .wdata (ks_data),
        .rdata (ks_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Intake stops at len keystream bytes, so nothing is left in the FIFO
    // when the message ends and the next message starts with it empty.
    assign ks_ready  = (state == ST_RUN) & ~fifo_full & (kcnt < len);
    assign din_ready = (state == ST_RUN) & ~fifo_empty & (~dout_valid | dout_ready);

    assign ks_fire   = ks_valid & ks_ready;
    assign din_fire  = din_valid & din_ready;
    assign dout_fire = dout_valid & dout_ready;
    assign start_ok  = (state == ST_IDLE) & start;
    assign last_byte = (dcnt == len - LEN_W'(1));

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (msg_len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_fire && last_byte) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dout_fire && dout_last) begin
                    state_nx = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Counters never wrap: kcnt is held below len by ks_ready and dcnt stops
    // advancing once the last byte moves the FSM out of RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len  <= '0;
            kcnt <= '0;
            dcnt <= '0;
        end else if (start_ok) begin
            len  <= msg_len;
            kcnt <= '0;
            dcnt <= '0;
        end else begin
            if (ks_fire) begin
                kcnt <= kcnt + LEN_W'(1);
            end
            if (din_fire) begin
                dcnt <= dcnt + LEN_W'(1);
            end
        end
    end

    // A load takes priority over a drain, which gives back-to-back bytes at
    // full rate. dout itself keeps its last value when nothing is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_last  <= 1'b0;
        end else if (din_fire) begin
            dout_valid <= 1'b1;
            dout       <= din ^ ks_head;
            dout_last  <= last_byte;
        end else if (dout_fire) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rc4_xor_stream.sv
module tb_rc4_xor_stream;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] msg_len;
    logic       ks_valid;
    logic [7:0] ks_data;
    logic       ks_ready;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout;
    logic       dout_last;
    logic       dout_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ks_vec  [16];
    logic [7:0] din_vec [16];
    logic [7:0] exp_vec [16];
    logic [7:0] out_q  [$];
    logic       last_q [$];

    int ks_hs, hold_err, lat_err, done_cnt, done_cyc, last_cyc, stall_seen;
    int timed_out;
    logic done_after, busy_after;

    rc4_xor_stream #(.KS_DEPTH(4), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg_len    (msg_len),
        .ks_valid   (ks_valid),
        .ks_data    (ks_data),
        .ks_ready   (ks_ready),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one message: ks_valid is held high throughout, din is offered
    // while bytes remain. Optional sink stall on output byte stall_idx,
    // optional start pulse at loop cycle start_at, optional early return
    // once abort_after output handshakes are committed.
    task automatic run_msg(input int n, input int stall_idx, input int stall_cyc,
                           input int start_at, input int abort_after);
        int   ki, di, cyc, stall_left;
        logic din_fire_prev, finished;
        logic [7:0] held;
        ki = 0; di = 0; cyc = 0; stall_left = stall_cyc;
        out_q.delete(); last_q.delete();
        ks_hs = 0; hold_err = 0; lat_err = 0; done_cnt = 0;
        done_cyc = -1; last_cyc = -1; stall_seen = 0; timed_out = 0;
        din_fire_prev = 1'b0; finished = 1'b0; held = 8'h00;
        done_after = 1'bx; busy_after = 1'bx;
        @(negedge clk);
        start = 1'b1; msg_len = n[7:0];
        @(negedge clk);
        start = 1'b0;
        while (!finished) begin
            ks_valid  = 1'b1;
            ks_data   = (ki < 16) ? ks_vec[ki] : 8'hEE;
            din_valid = (di < n) ? 1'b1 : 1'b0;
            din       = (di < 16) ? din_vec[di] : 8'h00;
            start     = (cyc == start_at) ? 1'b1 : 1'b0;
            msg_len   = (cyc == start_at) ? 8'd5 : n[7:0];
            dout_ready = 1'b1;
            if (dout_valid && out_q.size() == stall_idx && stall_left > 0) begin
                dout_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (din_fire_prev && !dout_valid) lat_err++;
            if (!dout_ready) begin
                if (stall_seen == 0) held = dout;
                else if (dout !== held) hold_err++;
                if (din_ready !== 1'b0) hold_err++;
                stall_seen++;
            end
            if (ks_valid && ks_ready) begin
                ks_hs++;
                ki++;
            end
            din_fire_prev = din_valid & din_ready;
            if (din_fire_prev) di++;
            if (dout_valid && dout_ready) begin
                out_q.push_back(dout);
                last_q.push_back(dout_last);
                if (dout_last) last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                finished = 1'b1;
            end
            if (abort_after >= 0 && out_q.size() == abort_after) finished = 1'b1;
            if (cyc >= 200) begin
                timed_out = 1;
                finished = 1'b1;
            end
            cyc++;
            if (!finished) @(negedge clk);
        end
        din_valid = 1'b0;
        start = 1'b0;
        if (abort_after < 0) begin
            @(negedge clk);
            #1;
            done_after = done;
            busy_after = busy;
        end
    endtask

    task automatic check_msg(input string tag, input int n);
        logic [7:0] obs;
        logic       lst;
        chk({tag, " timeout"}, timed_out, 0);
        chk({tag, " out_count"}, out_q.size(), n);
        chk({tag, " ks_handshakes"}, ks_hs, n);
        chk({tag, " latency"}, lat_err, 0);
        for (int i = 0; i < n; i++) begin
            obs = (i < out_q.size()) ? out_q[i] : 8'hxx;
            lst = (i < last_q.size()) ? last_q[i] : 1'bx;
            chk($sformatf("%s byte%0d", tag, i), {24'd0, obs}, {24'd0, exp_vec[i]});
            chk($sformatf("%s last%0d", tag, i), {31'd0, lst}, (i == n - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, " done_after"}, {31'd0, done_after}, 0);
        chk({tag, " busy_after"}, {31'd0, busy_after}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; msg_len = 8'd0;
        ks_valid = 1'b0; ks_data = 8'd0; din_valid = 1'b0; din = 8'd0;
        dout_ready = 1'b1;
        #1;
        chk("rst dout_valid", {31'd0, dout_valid}, 0);
        chk("rst dout", {24'd0, dout}, 0);
        chk("rst dout_last", {31'd0, dout_last}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst ks_ready", {31'd0, ks_ready}, 0);
        chk("rst din_ready", {31'd0, din_ready}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Case 1: basic 4-byte message
        ks_vec[0] = 8'h01; ks_vec[1] = 8'h02; ks_vec[2] = 8'h04; ks_vec[3] = 8'h08;
        din_vec[0] = 8'hF0; din_vec[1] = 8'hF1; din_vec[2] = 8'hF2; din_vec[3] = 8'hF3;
        exp_vec[0] = 8'hF1; exp_vec[1] = 8'hF3; exp_vec[2] = 8'hF6; exp_vec[3] = 8'hFB;
        run_msg(4, -1, 0, -1, -1);
        check_msg("c1", 4);
        chk("c1 done_one_after_last", done_cyc, last_cyc + 1);
        chk("c1 done_pulses", done_cnt, 1);
        ks_valid = 1'b0;

        // Case 2: sink stalls 3 cycles on byte 2
        run_msg(4, 1, 3, -1, -1);
        check_msg("c2", 4);
        chk("c2 stall_cycles", stall_seen, 3);
        chk("c2 hold", hold_err, 0);
        ks_valid = 1'b0;

        // Case 3: keystream always valid, msg_len=3 -> exactly 3 taken
        ks_vec[0] = 8'hAA; ks_vec[1] = 8'h55; ks_vec[2] = 8'h0F;
        ks_vec[3] = 8'h77; ks_vec[4] = 8'h77; ks_vec[5] = 8'h77;
        din_vec[0] = 8'h00; din_vec[1] = 8'hFF; din_vec[2] = 8'h3C;
        exp_vec[0] = 8'hAA; exp_vec[1] = 8'hAA; exp_vec[2] = 8'h33;
        run_msg(3, -1, 0, -1, -1);
        check_msg("c3", 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ks_valid = 1'b1;
            #1;
            chk($sformatf("c3 ks_ready_idle%0d", i), {31'd0, ks_ready}, 0);
        end
        ks_valid = 1'b0;

        // Case 4: zero-length message
        @(negedge clk);
        start = 1'b1; msg_len = 8'd0;
        #1;
        chk("c4 busy_at_start", {31'd0, busy}, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("c4 busy_fin", {31'd0, busy}, 1);
        chk("c4 done_fin", {31'd0, done}, 1);
        chk("c4 ks_ready_fin", {31'd0, ks_ready}, 0);
        chk("c4 din_ready_fin", {31'd0, din_ready}, 0);
        @(negedge clk);
        #1;
        chk("c4 busy_after", {31'd0, busy}, 0);
        chk("c4 done_after", {31'd0, done}, 0);

        // Case 5: encrypt 8 bytes (with an ignored start mid-message), then decrypt
        ks_vec[0] = 8'h3C; ks_vec[1] = 8'h7E; ks_vec[2] = 8'h00; ks_vec[3] = 8'hFF;
        ks_vec[4] = 8'h81; ks_vec[5] = 8'h42; ks_vec[6] = 8'h99; ks_vec[7] = 8'h10;
        din_vec[0] = 8'h48; din_vec[1] = 8'h65; din_vec[2] = 8'h6C; din_vec[3] = 8'h6C;
        din_vec[4] = 8'h6F; din_vec[5] = 8'h21; din_vec[6] = 8'h0A; din_vec[7] = 8'hFF;
        exp_vec[0] = 8'h74; exp_vec[1] = 8'h1B; exp_vec[2] = 8'h6C; exp_vec[3] = 8'h93;
        exp_vec[4] = 8'hEE; exp_vec[5] = 8'h63; exp_vec[6] = 8'h93; exp_vec[7] = 8'hEF;
        run_msg(8, -1, 0, 3, -1);
        check_msg("c5enc", 8);
        ks_valid = 1'b0;
        din_vec[0] = 8'h74; din_vec[1] = 8'h1B; din_vec[2] = 8'h6C; din_vec[3] = 8'h93;
        din_vec[4] = 8'hEE; din_vec[5] = 8'h63; din_vec[6] = 8'h93; din_vec[7] = 8'hEF;
        exp_vec[0] = 8'h48; exp_vec[1] = 8'h65; exp_vec[2] = 8'h6C; exp_vec[3] = 8'h6C;
        exp_vec[4] = 8'h6F; exp_vec[5] = 8'h21; exp_vec[6] = 8'h0A; exp_vec[7] = 8'hFF;
        run_msg(8, -1, 0, -1, -1);
        check_msg("c5dec", 8);
        ks_valid = 1'b0;

        // Case 6: reset after byte 2, then a fresh 2-byte message
        ks_vec[0] = 8'h11; ks_vec[1] = 8'h22; ks_vec[2] = 8'h33; ks_vec[3] = 8'h44;
        din_vec[0] = 8'h01; din_vec[1] = 8'h02; din_vec[2] = 8'h03; din_vec[3] = 8'h04;
        run_msg(4, -1, 0, -1, 2);
        chk("c6 pre_reset_timeout", timed_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("c6 rst dout_valid", {31'd0, dout_valid}, 0);
        chk("c6 rst dout", {24'd0, dout}, 0);
        chk("c6 rst dout_last", {31'd0, dout_last}, 0);
        chk("c6 rst busy", {31'd0, busy}, 0);
        chk("c6 rst done", {31'd0, done}, 0);
        chk("c6 rst ks_ready", {31'd0, ks_ready}, 0);
        chk("c6 rst din_ready", {31'd0, din_ready}, 0);
        ks_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ks_vec[0] = 8'h5A; ks_vec[1] = 8'hA5;
        din_vec[0] = 8'h12; din_vec[1] = 8'h34;
        exp_vec[0] = 8'h48; exp_vec[1] = 8'h91;
        run_msg(2, -1, 0, -1, -1);
        check_msg("c6", 2);
        ks_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
